branch_resolve_inst2: RTL and testbench
=======================================

# branch_resolve_inst2

Resolves conditional branches (beq/bne) issued in slot 2 in the EX stage of the dual-issue pipeline. It compares the actual branch outcome with the prediction carried down the ID/EX slot-2 register, and generates the decode-stage flush and fetch redirect that the ID/EX slot-2 register consumes. It also owns the 2-bit saturating branch history table (BHT) that fetch reads to produce that prediction. Two saturating event counters expose branch and mispredict totals for debug.

## Interface
Parameters:
- IDX_W, 4: BHT index width; table has 2^IDX_W entries.
- PC_W, 8: instruction-address width, matching the 8-bit branch target carried through ID/EX.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; clears all state.
- Branch_inst2_EX  in  1  slot-2 instruction in EX is a conditional branch.
- bit26_E_inst2  in  1  opcode bit 26: 0 = beq, 1 = bne.
- prediction_EX_2  in  1  prediction made at fetch for this branch (1 = taken).
- srcA_EX_inst2  in  32  post-forwarding rs operand.
- srcB_EX_inst2  in  32  post-forwarding rt operand.
- pcBranch_EX  in  PC_W  branch target address.
- pcPlus1_EX  in  PC_W  fall-through address.
- pc_EX_inst2  in  PC_W  branch's own address; used for the BHT update index.
- stall_E  in  1  EX held this cycle. Suppresses updates, counts and flush.
- pcF  in  PC_W  fetch address for the BHT lookup.
- predictionF  out  1  BHT prediction for pcF (combinational).
- flush_D_2  out  1  flush the ID/EX slot-2 register (combinational).
- flush_F  out  1  flush the IF/ID register (combinational, equal to flush_D_2).
- redirect_valid  out  1  fetch takes redirect_pc next edge.
- redirect_pc  out  PC_W  corrected fetch address.
- branch_count  out  16  resolved branches, saturating.
- mispredict_count  out  16  mispredicted branches, saturating.

## Operation
- Resolution is combinational, active only when `resolve = Branch_inst2_EX & ~stall_E`.
- `eq = (srcA_EX_inst2 == srcB_EX_inst2)`, compared over the full 32 bits.
- `actual_taken = eq ^ bit26_E_inst2`.
- `mispredict = resolve & (actual_taken != prediction_EX_2)`.
- `flush_D_2 = flush_F = redirect_valid = mispredict`.
- `redirect_pc = actual_taken ? pcBranch_EX : pcPlus1_EX`. It is 0 when mispredict is 0, so the output is never X-dependent.
- BHT:
  - Entry e = 2-bit counter. Prediction is taken iff e[1] = 1.
  - Update index = pc_EX_inst2[IDX_W-1:0]; lookup index = pcF[IDX_W-1:0].
  - On resolve, the indexed entry increments if actual_taken (saturating at 3), otherwise decrements (saturating at 0).
- Counters:
  - branch_count increments on every resolve.
  - mispredict_count increments on every mispredict.
  - Both hold at 16'hFFFF once reached.
- With stall_E high, all outputs except predictionF are 0 and no state changes.

## Timing
- Reset (asynchronous, reset = 0):
  - Every BHT entry = 2'b01 (weakly not-taken).
  - branch_count = mispredict_count = 0.
  - predictionF = 0.
  - flush_D_2, flush_F, redirect_valid, redirect_pc all = 0 when Branch_inst2_EX = 0.
- Resolve latency is 0 cycles: a mispredict in EX cycle N asserts flush/redirect in cycle N. At the edge ending cycle N:
  - the ID/EX slot-2 register loads a bubble;
  - fetch loads redirect_pc;
  - the BHT and counters update.
- Same-cycle lookup/update on the same index: predictionF returns the pre-update value. There is no write-to-read bypass.
- Back-to-back branches in consecutive cycles each update once. A branch held by stall_E for k cycles updates exactly once, in the cycle stall_E falls.
- Reset asserted mid-operation clears the BHT and counters immediately. Outputs follow the combinational rules on the current inputs.

## Structure
- Shared package `pipe_pkg`:
  - BHT state constants: SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - Opcode bit-26 meaning: BEQ=0, BNE=1.
  - Default PC_W.
- Sub-module `sat_counter2`: one 2-bit saturating counter with inc/dec/en. The BHT instantiates it 2^IDX_W times via generate.
- Event counters and resolve logic stay inline.

## Test plan
- Reset, then pcF=0x03 → predictionF=0. Fire one beq at pc 0x03 with srcA=srcB=5 and prediction=0 → flush_D_2=1, redirect_pc=pcBranch_EX (0x40), mispredict_count=1, and next cycle predictionF=1 for pcF=0x03.
- bne at pc 0x05 with srcA=7, srcB=7, prediction=0 → not taken, flush_D_2=0, branch_count increments, and BHT[5] saturates 01→00→00 over two repeats.
- Four consecutive taken beq at pc 0x02 → BHT[2] goes 01→10→11→11. Only the first (prediction=0) flushes; mispredict_count=1.
- Branch held with stall_E=1 for 3 cycles, then released → no flush during the stall and exactly one BHT/counter update on release.
- Update and lookup on index 0x6 in the same cycle → predictionF shows the old value (0), then 1 the next cycle. Force branch_count to 0xFFFF → it stays 0xFFFF.
- Assert reset mid-stream after mispredicts → counters read 0 and all BHT entries read 01 without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline constants: BHT counter states, branch opcode
// bit-26 meaning and the default instruction-address width.
package pipe_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_e;

  localparam logic BEQ = 1'b0;
  localparam logic BNE = 1'b1;

  localparam int PC_W_DEF = 8;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/branch_resolve_inst2_sat_counter2.sv
// One 2-bit saturating branch-history counter.
// Resets to weakly not-taken; moves one step per enabled update.
module sat_counter2
  import pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       inc,
  output logic [1:0] cnt
);

  bht_e cnt_q;
  bht_e cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      unique case (cnt_q)
        SNT: cnt_d = inc ? WNT : SNT;
        WNT: cnt_d = inc ? WT  : SNT;
        WT:  cnt_d = inc ? ST  : WNT;
        ST:  cnt_d = inc ? ST  : WT;
        default: cnt_d = WNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= WNT;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/branch_resolve_inst2.sv
// Slot-2 beq/bne resolution in EX: mispredict flush/redirect,
// the fetch-side BHT and saturating debug event counters.
module branch_resolve_inst2
  import pipe_pkg::*;
#(
  parameter int IDX_W = 4,
  parameter int PC_W  = PC_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Branch_inst2_EX,
  input  logic            bit26_E_inst2,
  input  logic            prediction_EX_2,
  input  logic [31:0]     srcA_EX_inst2,
  input  logic [31:0]     srcB_EX_inst2,
  input  logic [PC_W-1:0] pcBranch_EX,
  input  logic [PC_W-1:0] pcPlus1_EX,
  input  logic [PC_W-1:0] pc_EX_inst2,
  input  logic            stall_E,
  input  logic [PC_W-1:0] pcF,
  output logic            predictionF,
  output logic            flush_D_2,
  output logic            flush_F,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic [15:0]     branch_count,
  output logic [15:0]     mispredict_count
);

  localparam int BHT_N = 1 << IDX_W;

  logic             resolve;
  logic             eq;
  logic             actual_taken;
  logic             mispredict;
  logic [IDX_W-1:0] upd_idx;
  logic [IDX_W-1:0] lkp_idx;
  logic [1:0]       bht [BHT_N];

  logic [15:0] branch_count_q;
  logic [15:0] branch_count_d;
  logic [15:0] mispredict_count_q;
  logic [15:0] mispredict_count_d;

  assign upd_idx = pc_EX_inst2[IDX_W-1:0];
  assign lkp_idx = pcF[IDX_W-1:0];

  // High PC bits only matter to the redirect, not the table index.
  logic unused_pc_hi;
  assign unused_pc_hi = ^{pc_EX_inst2[PC_W-1:IDX_W],
                          pcF[PC_W-1:IDX_W]};

  always_comb begin
    resolve      = Branch_inst2_EX & ~stall_E;
    eq           = (srcA_EX_inst2 == srcB_EX_inst2);
    actual_taken = eq ^ (bit26_E_inst2 == BNE);
    mispredict   = resolve & (actual_taken != prediction_EX_2);
    redirect_pc  = '0;
    if (mispredict) begin
      redirect_pc = actual_taken ? pcBranch_EX : pcPlus1_EX;
    end
  end

  assign flush_D_2      = mispredict;
  assign flush_F        = mispredict;
  assign redirect_valid = mispredict;

  for (genvar i = 0; i < BHT_N; i++) begin : g_bht
    sat_counter2 u_ctr (
      .clk   (clk),
      .rst_n (reset),
      .en    (resolve && (upd_idx == IDX_W'(i))),
      .inc   (actual_taken),
      .cnt   (bht[i])
    );
  end

  // Lookup reads the registered entry: no same-cycle bypass.
  assign predictionF = bht[lkp_idx][1];

  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (resolve && branch_count_q != CNT_MAX) begin
      branch_count_d = branch_count_q + 16'd1;
    end
    if (mispredict && mispredict_count_q != CNT_MAX) begin
      mispredict_count_d = mispredict_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_resolve_inst2.sv
// Bench for branch_resolve_inst2: vector table, corner sequences,
// random stimulus against a behavioural model, saturation, reset.
module tb_branch_resolve_inst2;

  logic        clk;
  logic        rst_n;
  logic        br;
  logic        bne;
  logic        pred;
  logic [31:0] a;
  logic [31:0] b;
  logic [7:0]  tgt;
  logic [7:0]  p1;
  logic [7:0]  pcex;
  logic        stall;
  logic [7:0]  pcf;
  logic        pred_f;
  logic        fl_d;
  logic        fl_f;
  logic        rv;
  logic [7:0]  rpc;
  logic [15:0] bcnt;
  logic [15:0] mcnt;

  int n_cmp;
  int n_bad;

  int bht_m [16];
  int bc_m;
  int mc_m;

  branch_resolve_inst2 dut (
    .clk              (clk),
    .reset            (rst_n),
    .Branch_inst2_EX  (br),
    .bit26_E_inst2    (bne),
    .prediction_EX_2  (pred),
    .srcA_EX_inst2    (a),
    .srcB_EX_inst2    (b),
    .pcBranch_EX      (tgt),
    .pcPlus1_EX       (p1),
    .pc_EX_inst2      (pcex),
    .stall_E          (stall),
    .pcF              (pcf),
    .predictionF      (pred_f),
    .flush_D_2        (fl_d),
    .flush_F          (fl_f),
    .redirect_valid   (rv),
    .redirect_pc      (rpc),
    .branch_count     (bcnt),
    .mispredict_count (mcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        br;
    logic        bne;
    logic        pred;
    logic        stall;
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  pc;
    logic [7:0]  tgt;
    logic [7:0]  p1;
    logic [7:0]  pcf;
    logic        exp_flush;
    logic [7:0]  exp_rpc;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  function automatic bit m_taken();
    return (a == b) ^ bne;
  endfunction

  function automatic bit m_resolve();
    return br && !stall;
  endfunction

  function automatic bit m_misp();
    return m_resolve() && (m_taken() != pred);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) bht_m[i] = 1;
    bc_m = 0;
    mc_m = 0;
  endtask

  task automatic check_all(input string nm);
    logic [7:0] er;
    er = m_misp() ? (m_taken() ? tgt : p1) : 8'h00;
    chk({nm, ".predF"}, 32'(pred_f), 32'(bht_m[pcf[3:0]] >= 2));
    chk({nm, ".flushD"}, 32'(fl_d), 32'(m_misp()));
    chk({nm, ".flushF"}, 32'(fl_f), 32'(m_misp()));
    chk({nm, ".rv"}, 32'(rv), 32'(m_misp()));
    chk({nm, ".rpc"}, 32'(rpc), 32'(er));
    chk({nm, ".bcnt"}, 32'(bcnt), 32'(bc_m));
    chk({nm, ".mcnt"}, 32'(mcnt), 32'(mc_m));
  endtask

  // Advance one clock, applying the architectural update rules.
  task automatic tick();
    int k;
    if (m_resolve()) begin
      k = int'(pcex[3:0]);
      if (m_taken()) bht_m[k] = (bht_m[k] == 3) ? 3 : bht_m[k] + 1;
      else           bht_m[k] = (bht_m[k] == 0) ? 0 : bht_m[k] - 1;
      if (bc_m < 65535) bc_m++;
      if (m_misp() && mc_m < 65535) mc_m++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    br = 0; bne = 0; pred = 0; stall = 0;
    a = 0; b = 0; tgt = 0; p1 = 0; pcex = 0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    m_reset();
    idle();
    pcf = 8'h03;
    rst_n = 0;
    #12;
    chk("rst.predF", 32'(pred_f), 0);
    chk("rst.flush", 32'(fl_d), 0);
    chk("rst.rpc", 32'(rpc), 0);
    chk("rst.bcnt", 32'(bcnt), 0);
    chk("rst.mcnt", 32'(mcnt), 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    vt[0]  = '{1,0,0,0, 32'd5, 32'd5, 8'h03, 8'h40, 8'h04, 8'h03,
               1, 8'h40};
    vt[1]  = '{1,1,0,0, 32'd7, 32'd7, 8'h05, 8'h50, 8'h06, 8'h03,
               0, 8'h00};
    vt[2]  = '{1,1,0,0, 32'd7, 32'd7, 8'h05, 8'h50, 8'h06, 8'h05,
               0, 8'h00};
    vt[3]  = '{1,0,0,0, 32'd9, 32'd9, 8'h02, 8'h20, 8'h03, 8'h05,
               1, 8'h20};
    vt[4]  = '{1,0,1,0, 32'd9, 32'd9, 8'h02, 8'h20, 8'h03, 8'h02,
               0, 8'h00};
    vt[5]  = '{1,0,1,0, 32'd9, 32'd9, 8'h02, 8'h20, 8'h03, 8'h02,
               0, 8'h00};
    vt[6]  = '{1,0,1,0, 32'd9, 32'd9, 8'h02, 8'h20, 8'h03, 8'h02,
               0, 8'h00};
    vt[7]  = '{1,1,1,0, 32'd1, 32'd2, 8'h07, 8'h70, 8'h08, 8'h02,
               0, 8'h00};
    vt[8]  = '{1,0,1,0, 32'h8000_0001, 32'd1, 8'h08, 8'h80, 8'h09,
               8'h07, 1, 8'h09};
    vt[9]  = '{1,0,0,1, 32'd3, 32'd3, 8'h09, 8'h90, 8'h0a, 8'h08,
               0, 8'h00};
    vt[10] = '{0,0,0,0, 32'd3, 32'd3, 8'h09, 8'h90, 8'h0a, 8'h02,
               0, 8'h00};

    for (int i = 0; i < 11; i++) begin
      br = vt[i].br; bne = vt[i].bne; pred = vt[i].pred;
      stall = vt[i].stall; a = vt[i].a; b = vt[i].b;
      pcex = vt[i].pc; tgt = vt[i].tgt; p1 = vt[i].p1;
      pcf = vt[i].pcf;
      #1;
      chk($sformatf("vec%0d.flush", i), 32'(fl_d),
          32'(vt[i].exp_flush));
      chk($sformatf("vec%0d.rpc", i), 32'(rpc), 32'(vt[i].exp_rpc));
      check_all($sformatf("vec%0d", i));
      tick();
    end
    idle();
    pcf = 8'h03;
    #1;
    chk("bht3.taken", 32'(pred_f), 1);
    chk("cnt.mcnt", 32'(mcnt), 3);
    chk("cnt.bcnt", 32'(bcnt), 9);

    // Branch held by stall for three cycles, then released.
    br = 1; bne = 0; pred = 0; a = 4; b = 4;
    pcex = 8'h0b; tgt = 8'hb0; p1 = 8'h0c; pcf = 8'h0b;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_all($sformatf("stall%0d", i));
      tick();
    end
    stall = 0;
    #1;
    check_all("release");
    tick();
    idle();
    pcf = 8'h0b;
    #1;
    check_all("post_release");
    chk("post_release.bcnt", 32'(bcnt), 10);

    // Same-cycle update and lookup on index 6.
    br = 1; bne = 0; pred = 0; a = 1; b = 1;
    pcex = 8'h06; tgt = 8'h60; p1 = 8'h07; pcf = 8'h06;
    #1;
    chk("bypass.old", 32'(pred_f), 0);
    tick();
    idle();
    #1;
    chk("bypass.new", 32'(pred_f), 1);

    for (int i = 0; i < 400; i++) begin
      br = 1'($urandom_range(0, 3) != 0);
      bne = 1'($urandom);
      pred = 1'($urandom);
      stall = 1'($urandom_range(0, 3) == 0);
      a = $urandom_range(0, 3);
      b = ($urandom_range(0, 7) == 0) ? a ^ 32'h8000_0000
                                      : 32'($urandom_range(0, 3));
      tgt = 8'($urandom);
      p1 = 8'($urandom);
      pcex = 8'($urandom);
      pcf = 8'($urandom);
      #1;
      check_all("rand");
      tick();
    end

    // Drive both counters to saturation with mispredicting branches.
    br = 1; stall = 0; bne = 0; a = 2; b = 2; pred = 0;
    tgt = 8'h11; p1 = 8'h22;
    for (int i = 0; i < 65540; i++) begin
      pcex = 8'(i);
      tick();
    end
    pcf = 8'h0e;
    #1;
    chk("sat.bcnt", 32'(bcnt), 32'hFFFF);
    chk("sat.mcnt", 32'(mcnt), 32'hFFFF);
    check_all("sat");
    tick();
    chk("sat.hold", 32'(bcnt), 32'hFFFF);

    // Asynchronous reset between edges.
    idle();
    #2;
    rst_n = 0;
    m_reset();
    #1;
    chk("arst.bcnt", 32'(bcnt), 0);
    chk("arst.mcnt", 32'(mcnt), 0);
    for (int i = 0; i < 16; i++) begin
      pcf = 8'(i);
      #0.1;
      chk($sformatf("arst.bht%0d", i), 32'(pred_f), 0);
    end
    @(negedge clk);
    rst_n = 1;
    br = 1; bne = 0; pred = 0; a = 6; b = 6;
    pcex = 8'h02; tgt = 8'h33; p1 = 8'h03; pcf = 8'h02;
    #1;
    check_all("post_arst");
    tick();
    idle();
    #1;
    check_all("post_arst2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
